// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI_master between NREQ requesters.
// Ports: req/req_data/req_mode/cfg_rate in, gnt/done/err/busy out,
//        in_DATA/mode/clk_RATE/ss_trig to SPI_master, sl_se from SPI_master.
module spi_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TRIG_W  = 2,
    parameter int TIMEOUT = 1023,
    parameter bit SS_ACT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [2*NREQ-1:0] req_mode,
    input  logic [4:0]        cfg_rate,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              busy,
    output logic [7:0]        in_DATA,
    output logic [1:0]        mode,
    output logic [4:0]        clk_RATE,
    output logic              ss_trig,
    input  logic              sl_se
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TRIG, S_WAIT, S_BUSY, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] ptr, win, pick;
    logic [9:0]    timer;
    logic [15:0]   tcnt;
    logic          ss_s1, ss_s2;
    logic          ss_on;
    logic          trig_end;
    logic          tmo;
    int            idx;

    assign ss_on    = (ss_s2 == SS_ACT);
    assign trig_end = (tcnt == 16'(TRIG_W - 1));
    // Leaving on this edge puts ERR exactly TIMEOUT cycles after WAIT entry.
    assign tmo      = (timer == 10'(TIMEOUT - 1));

    // Search downward so the last hit is the nearest one at or after ptr.
    always_comb begin
        pick = ptr;
        idx  = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[PW'(idx)]) pick = PW'(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (|req) state_nx = S_LOAD;
            S_LOAD: state_nx = S_TRIG;
            S_TRIG: if (trig_end) state_nx = S_WAIT;
            S_WAIT: begin
                if (ss_on)    state_nx = S_BUSY;
                else if (tmo) state_nx = S_ERR;
            end
            S_BUSY: begin
                if (!ss_on)   state_nx = S_DONE;
                else if (tmo) state_nx = S_ERR;
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        ss_trig = (state == S_TRIG);
        err     = (state == S_ERR);
        done    = (state == S_DONE || state == S_ERR) ? gnt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_s1    <= ~SS_ACT;
            ss_s2    <= ~SS_ACT;
            ptr      <= '0;
            win      <= '0;
            gnt      <= '0;
            in_DATA  <= '0;
            mode     <= '0;
            clk_RATE <= '0;
            timer    <= '0;
            tcnt     <= '0;
        end else begin
            ss_s1 <= sl_se;
            ss_s2 <= ss_s1;
            if (state == S_IDLE) win <= pick;
            if (state == S_LOAD) begin
                gnt      <= NREQ'(1) << win;
                in_DATA  <= req_data[8*win +: 8];
                mode     <= req_mode[2*win +: 2];
                clk_RATE <= cfg_rate;
            end
            tcnt <= (state == S_TRIG) ? tcnt + 16'd1 : '0;
            if ((state == S_TRIG && trig_end) ||
                (state == S_WAIT && ss_on))
                timer <= '0;
            else if ((state == S_WAIT || state == S_BUSY) && timer != '1)
                timer <= timer + 10'd1;
            if (state == S_DONE || state == S_ERR) begin
                gnt <= '0;
                ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Randomized self-checking bench for spi_req_arbiter.
// Reference: round-robin pointer model plus an SPI_master sl_se model.
`timescale 1ns/1ps
module tb_spi_req_arbiter;
    localparam int NREQ   = 4;
    localparam int TRIG_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [2*NREQ-1:0] req_mode;
    logic [4:0]        cfg_rate;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              busy;
    logic [7:0]        in_DATA;
    logic [1:0]        mode;
    logic [4:0]        clk_RATE;
    logic              ss_trig;
    logic              sl_se;

    int n_chk  = 0;
    int n_pass = 0;
    int ptr_m  = 0;

    spi_req_arbiter #(.NREQ(NREQ), .TRIG_W(TRIG_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .req_mode(req_mode), .cfg_rate(cfg_rate), .gnt(gnt),
        .done(done), .err(err), .busy(busy), .in_DATA(in_DATA),
        .mode(mode), .clk_RATE(clk_RATE), .ss_trig(ss_trig),
        .sl_se(sl_se)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // First active requester at or after the pointer, wrapping around.
    function automatic int exp_win(input logic [NREQ-1:0] r, input int p);
        logic [2*NREQ-1:0] rr;
        rr = {r, r} >> p;
        for (int k = 0; k < NREQ; k++)
            if (rr[k]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic xfer(input logic [NREQ-1:0] r, input logic [31:0] d,
                        input logic [7:0] m, input logic [4:0] rate,
                        input int hold, input bit drop, output int w);
        logic [7:0] ed;
        logic [1:0] em;
        w        = exp_win(r, ptr_m);
        ed       = 8'(d >> (8 * w));
        em       = 2'(m >> (2 * w));
        req      = r;
        req_data = d;
        req_mode = m;
        cfg_rate = rate;
        @(negedge clk);
        chk("load_busy", 32'(busy), 1);
        chk("load_trig", 32'(ss_trig), 0);
        for (int i = 0; i < TRIG_W; i++) begin
            @(negedge clk);
            chk("trig_hi", 32'(ss_trig), 1);
            if (i == 0) begin
                chk("gnt", 32'(gnt), 32'(1) << w);
                chk("in_data", 32'(in_DATA), 32'(ed));
                chk("mode", 32'(mode), 32'(em));
                chk("rate", 32'(clk_RATE), 32'(rate));
            end
        end
        @(negedge clk);
        chk("trig_lo", 32'(ss_trig), 0);
        sl_se    = 1'b0;
        req_data = $urandom;
        req_mode = 8'($urandom);
        cfg_rate = 5'($urandom);
        if (drop) req = r & ~(4'(1) << w);
        repeat (hold) begin
            @(negedge clk);
            chk("busy_nodone", 32'(done), 0);
            chk("stable_data", 32'(in_DATA), 32'(ed));
            chk("stable_rate", 32'(clk_RATE), 32'(rate));
            chk("stable_mode", 32'(mode), 32'(em));
        end
        sl_se = 1'b1;
        @(negedge clk);
        chk("rel1_done", 32'(done), 0);
        @(negedge clk);
        chk("rel2_done", 32'(done), 0);
        @(negedge clk);
        chk("done", 32'(done), 32'(1) << w);
        chk("done_err", 32'(err), 0);
        req   = '0;
        ptr_m = (w + 1) % NREQ;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_gnt", 32'(gnt), 0);
        chk("idle_done", 32'(done), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        sl_se = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
    endtask

    initial begin
        int w, n;
        int ord[4];
        rst_n    = 1'b0;
        req      = 4'b1111;
        req_data = 32'hFFFF_FFFF;
        req_mode = 8'hFF;
        cfg_rate = 5'h1F;
        sl_se    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_trig", 32'(ss_trig), 0);
        chk("rst_outs", {in_DATA, mode, clk_RATE, done, err}, 0);
        req   = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);

        xfer(4'b0100, 32'h1189_3344, 8'hE4, 5'd10, 4, 1'b0, w);
        chk("t2_win", w, 2);

        do_reset();
        for (int i = 0; i < 4; i++)
            xfer(4'b1011, $urandom, 8'($urandom), 5'($urandom),
                 3 + (i % 2), 1'b0, ord[i]);
        chk("rr0", ord[0], 0);
        chk("rr1", ord[1], 1);
        chk("rr2", ord[2], 3);
        chk("rr3", ord[3], 0);

        req = 4'b0001;
        @(negedge clk);
        repeat (TRIG_W) @(negedge clk);
        @(negedge clk);
        chk("to_start", 32'(err), 0);
        n = 0;
        while (err == 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 1023);
        chk("to_done", 32'(done), 32'b0001);
        req   = '0;
        ptr_m = 1;
        @(negedge clk);
        chk("to_idle", 32'(busy), 0);
        chk("to_err_pulse", 32'(err), 0);

        req = 4'b0100;
        @(negedge clk);
        repeat (TRIG_W) @(negedge clk);
        @(negedge clk);
        sl_se = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst", {gnt, busy, ss_trig, done, err}, 0);
        chk("t5_cfg", {in_DATA, mode, clk_RATE}, 0);
        sl_se = 1'b1;
        req   = '0;
        @(negedge clk);
        chk("t5_nodone", 32'(done), 0);
        rst_n = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        xfer(4'b1111, $urandom, 8'($urandom), 5'($urandom), 3, 1'b0, w);
        chk("t5_ptr0", w, 0);

        for (int i = 0; i < 12; i++)
            xfer(4'($urandom_range(1, 15)), $urandom, 8'($urandom),
                 5'($urandom), int'($urandom_range(3, 8)),
                 1'($urandom), w);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
